// File: rtl/axi_w_sequencer.sv
// AXI W-channel sequencer: queues write grants and routes W beats from the
// granted slave port, one burst at a time, in grant order.
module axi_w_sequencer #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int FIFO_DEPTH  = 4,
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     push_ID_i,
  input  logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_i,
  output logic                                     grant_FIFO_ID_o,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]   wdata_i,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0] wstrb_i,
  input  logic [N_TARG_PORT-1:0]                   wlast_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   wuser_i,
  input  logic [N_TARG_PORT-1:0]                   wvalid_i,
  output logic [N_TARG_PORT-1:0]                   wready_o,
  output logic [AXI_DATA_W-1:0]                    wdata_o,
  output logic [AXI_DATA_W/8-1:0]                  wstrb_o,
  output logic                                     wlast_o,
  output logic [AXI_USER_W-1:0]                    wuser_o,
  output logic                                     wvalid_o,
  input  logic                                     wready_i,
  output logic [7:0]                               beat_cnt_o,
  output logic                                     busy_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                 state, state_nxt;
  logic [N_TARG_PORT-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [N_TARG_PORT-1:0] sel;
  logic                   reload, reload_nxt, load_sel;
  logic [7:0]             beat_cnt;
  logic                   push, pop, hs, routing;
  logic [LOG_N_TARG-1:0]  unused_bin_id;

  // Routing uses the one-hot half of the tag; the binary index is not needed.
  assign unused_bin_id   = ID_i[LOG_N_TARG+N_TARG_PORT-1:N_TARG_PORT];
  assign grant_FIFO_ID_o = (count != FULL);
  assign push            = push_ID_i & grant_FIFO_ID_o;
  assign routing         = (state == ROUTE) & ~reload;
  assign hs              = wvalid_o & wready_i;
  assign pop             = hs & wlast_o;
  assign busy_o          = (state == ROUTE);
  assign beat_cnt_o      = beat_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      reload <= 1'b0;
    end else begin
      state  <= state_nxt;
      reload <= reload_nxt;
    end
  end

  // reload marks the bubble cycle in which sel picks up the next head.
  always_comb begin
    state_nxt  = state;
    load_sel   = 1'b0;
    reload_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = ROUTE;
          load_sel  = 1'b1;
        end
      end
      ROUTE: begin
        if (reload) begin
          load_sel = 1'b1;
        end else if (pop) begin
          if (count == ONE && !push) state_nxt = IDLE;
          else reload_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + ONE;
      else if (pop && !push) count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ID_i[N_TARG_PORT-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel      <= '0;
      beat_cnt <= '0;
    end else begin
      if (load_sel) sel <= fifo_mem[rd_ptr];
      if (pop)                            beat_cnt <= '0;
      else if (hs && beat_cnt != 8'hFF)   beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_comb begin
    wvalid_o = 1'b0;
    wready_o = '0;
    wdata_o  = '0;
    wstrb_o  = '0;
    wlast_o  = 1'b0;
    wuser_o  = '0;
    if (routing) begin
      wvalid_o = |(wvalid_i & sel);
      wready_o = sel & {N_TARG_PORT{wready_i}};
      for (int p = 0; p < N_TARG_PORT; p++) begin
        if (sel[p]) begin
          wdata_o = wdata_o | wdata_i[p];
          wstrb_o = wstrb_o | wstrb_i[p];
          wlast_o = wlast_o | wlast_i[p];
          wuser_o = wuser_o | wuser_i[p];
        end
      end
    end
  end

endmodule
